// File: rtl/ringn_pkg.sv
// Shared constants and step-selector encoding for the ringn_bd shift counter.
package ringn_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;
  localparam logic DIR_LEFT     = 1'b0;
  localparam logic DIR_RIGHT    = 1'b1;

  // Shift operation selected by {mode, dir}.
  typedef enum logic [1:0] {
    STEP_RING_L = 2'b00,
    STEP_RING_R = 2'b01,
    STEP_JOHN_L = 2'b10,
    STEP_JOHN_R = 2'b11
  } step_e;

endpackage

// File: rtl/ringn_legal_chk.sv
// Combinational legality check for a ring (one-hot) or Johnson (single transition) pattern.
module ringn_legal_chk
  import ringn_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         mode,
  input  logic [W-1:0] c,
  output logic         legal
);

  localparam int CW = $clog2(W + 1);

  logic [CW-1:0] ones_s;
  logic [CW-1:0] edges_s;

  // Count set bits and adjacent-bit transitions, then judge against the active mode.
  always_comb begin
    ones_s  = '0;
    edges_s = '0;
    for (int i = 0; i < W; i++) begin
      ones_s = ones_s + {{(CW-1){1'b0}}, c[i]};
    end
    for (int i = 0; i < W - 1; i++) begin
      edges_s = edges_s + {{(CW-1){1'b0}}, c[i] ^ c[i+1]};
    end
    if (mode == MODE_JOHNSON) begin
      legal = (edges_s <= CW'(1));
    end else begin
      legal = (ones_s == CW'(1));
    end
  end

endmodule

// File: rtl/ringn_bd.sv
// W-bit bidirectional ring/Johnson shift counter with parallel load and wrap pulse.
// Optional feature macro: RINGN_SELF_CORRECT_EN -- a step from a state that is illegal
// for the current mode restores RESET_PAT and pulses err instead of shifting.
module ringn_bd
  import ringn_pkg::*;
#(
  parameter int           W         = 4,
  parameter logic [W-1:0] RESET_PAT = {{(W-1){1'b0}}, 1'b1}
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic         dir,
  input  logic         mode,
  input  logic [W-1:0] data,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         err
);

  logic [W-1:0] count_r;
  logic         wrap_r;
  logic         err_r;

  step_e        step_sel_s;
  logic [W-1:0] shift_s;
  logic         fix_s;
  logic [W-1:0] count_nxt_s;
  logic         wrap_nxt_s;
  logic         err_nxt_s;

`ifdef RINGN_SELF_CORRECT_EN
  logic legal_s;

  ringn_legal_chk #(.W(W)) u_legal_chk (
    .mode  (mode),
    .c     (count_r),
    .legal (legal_s)
  );

  assign fix_s = ~legal_s;
`else
  assign fix_s = 1'b0;
`endif

  // Shifted value of the current state for the selected mode and direction.
  always_comb begin
    step_sel_s = step_e'({mode, dir});
    case (step_sel_s)
      STEP_RING_L: shift_s = {count_r[W-2:0], count_r[W-1]};
      STEP_RING_R: shift_s = {count_r[0], count_r[W-1:1]};
      STEP_JOHN_L: shift_s = {count_r[W-2:0], ~count_r[W-1]};
      STEP_JOHN_R: shift_s = {~count_r[0], count_r[W-1:1]};
      default:     shift_s = count_r;
    endcase
  end

  // Next-state selection: load beats step, step beats hold; wrap only follows a step.
  always_comb begin
    count_nxt_s = count_r;
    wrap_nxt_s  = 1'b0;
    err_nxt_s   = 1'b0;
    if (load) begin
      count_nxt_s = data;
    end else if (en) begin
      if (fix_s) begin
        count_nxt_s = RESET_PAT;
        err_nxt_s   = 1'b1;
      end else begin
        count_nxt_s = shift_s;
      end
      wrap_nxt_s = (count_nxt_s == RESET_PAT);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_r <= RESET_PAT;
      wrap_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      wrap_r  <= wrap_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  assign count = count_r;
  assign wrap  = wrap_r;
  assign err   = err_r;

endmodule

// File: tb/tb_ringn_bd.sv
// Self-checking bench for ringn_bd (W=4, RESET_PAT=0001): directed sequences plus
// randomized traffic compared against an arithmetic reference model.
module tb_ringn_bd;

  localparam int W    = 4;
  localparam int RPAT = 1;
  localparam int FULL = 1 << W;
  localparam int TOPB = 1 << (W - 1);

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         en    = 1'b0;
  logic         load  = 1'b0;
  logic         dir   = 1'b0;
  logic         mode  = 1'b0;
  logic [W-1:0] data  = '0;
  logic [W-1:0] count;
  logic         wrap;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_c = RPAT;
  int m_w = 0;
  int m_e = 0;
  bit ring_ok [FULL];
  bit john_ok [FULL];

  ringn_bd #(.W(W), .RESET_PAT(4'b0001)) dut (
    .clock (clock),
    .reset (reset),
    .en    (en),
    .load  (load),
    .dir   (dir),
    .mode  (mode),
    .data  (data),
    .count (count),
    .wrap  (wrap),
    .err   (err)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Successor of c treated as an integer: rotate (ring) or twisted rotate (Johnson).
  function automatic int m_next(int c, logic m, logic d);
    if (m == 1'b0 && d == 1'b0) return (c * 2) % FULL + c / TOPB;
    if (m == 1'b0 && d == 1'b1) return c / 2 + (c % 2) * TOPB;
    if (m == 1'b1 && d == 1'b0) return (c * 2) % FULL + (1 - c / TOPB);
    return c / 2 + (1 - c % 2) * TOPB;
  endfunction

  function automatic bit m_legal(int c, logic m);
    return m ? john_ok[c] : ring_ok[c];
  endfunction

  task automatic model_edge();
    if (!reset) begin
      m_c = RPAT; m_w = 0; m_e = 0;
    end else if (load) begin
      m_c = int'(data); m_w = 0; m_e = 0;
    end else if (en) begin
      m_e = 0;
`ifdef RINGN_SELF_CORRECT_EN
      if (!m_legal(m_c, mode)) begin
        m_c = RPAT; m_e = 1;
      end else begin
        m_c = m_next(m_c, mode, dir);
      end
`else
      m_c = m_next(m_c, mode, dir);
`endif
      m_w = (m_c == RPAT) ? 1 : 0;
    end else begin
      m_w = 0; m_e = 0;
    end
  endtask

  // Apply inputs for one edge, advance the model, and compare after the edge.
  task automatic cyc(input string tag, input logic r, input logic l, input logic e,
                     input logic d, input logic m, input logic [W-1:0] dat);
    reset = r; load = l; en = e; dir = d; mode = m; data = dat;
    model_edge();
    @(posedge clock);
    #1;
    check_val({tag, ".count"}, 32'(count), 32'(m_c));
    check_val({tag, ".wrap"},  32'(wrap),  32'(m_w));
    check_val({tag, ".err"},   32'(err),   32'(m_e));
  endtask

  // Model-independent literal expectations for the directed sequences.
  task automatic expect_lit(input string tag, input logic [W-1:0] c, input logic w, input logic e);
    check_val({tag, ".lit_count"}, 32'(count), 32'(c));
    check_val({tag, ".lit_wrap"},  32'(wrap),  32'(w));
    check_val({tag, ".lit_err"},   32'(err),   32'(e));
  endtask

  initial begin
    logic [W-1:0] ring_seq_l [4];
    logic [W-1:0] ring_seq_r [4];
    logic [W-1:0] john_seq   [8];
    int j;

    for (int i = 0; i < W; i++) ring_ok[1 << i] = 1'b1;
    j = 0;
    for (int i = 0; i < 2 * W; i++) begin
      john_ok[j] = 1'b1;
      j = m_next(j, 1'b1, 1'b0);
    end

    ring_seq_l = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    ring_seq_r = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    john_seq   = '{4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001};

    // 1. reset dominates load and en
    cyc("t1_rst0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1111);
    cyc("t1_rst1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1111);
    expect_lit("t1", 4'b0001, 1'b0, 1'b0);

    // 2. ring left
    for (int i = 0; i < 4; i++) begin
      cyc($sformatf("t2_s%0d", i), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
      expect_lit($sformatf("t2_s%0d", i), ring_seq_l[i], (i == 3), 1'b0);
    end

    // 3. ring right, then hold
    for (int i = 0; i < 4; i++) begin
      cyc($sformatf("t3_s%0d", i), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
      expect_lit($sformatf("t3_s%0d", i), ring_seq_r[i], (i == 3), 1'b0);
    end
    cyc("t3_hold", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1010);
    expect_lit("t3_hold", 4'b0001, 1'b0, 1'b0);

    // 4. Johnson left, full period
    for (int i = 0; i < 8; i++) begin
      cyc($sformatf("t4_s%0d", i), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
      expect_lit($sformatf("t4_s%0d", i), john_seq[i], (i == 7), 1'b0);
    end

    // 5. load an illegal ring pattern and step
    cyc("t5_load", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1001);
    expect_lit("t5_load", 4'b1001, 1'b0, 1'b0);
    cyc("t5_step", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
`ifdef RINGN_SELF_CORRECT_EN
    expect_lit("t5_step", 4'b0001, 1'b1, 1'b1);
`else
    expect_lit("t5_step", 4'b0011, 1'b0, 1'b0);
`endif

    // 6. reset in the middle of a Johnson sequence
    cyc("t6_load", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001);
    cyc("t6_j1",   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
    cyc("t6_j2",   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
    expect_lit("t6_mid", 4'b0111, 1'b0, 1'b0);
    cyc("t6_rst",  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1100);
    expect_lit("t6_rst", 4'b0001, 1'b0, 1'b0);
    cyc("t6_ring", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
    expect_lit("t6_ring", 4'b0010, 1'b0, 1'b0);

    // Randomized traffic: mode/dir flips, loads of arbitrary patterns, occasional reset
    for (int i = 0; i < 600; i++) begin
      cyc($sformatf("rnd%0d", i),
          ($urandom_range(31, 0) != 0),
          ($urandom_range(9, 0) == 0),
          ($urandom_range(3, 0) != 0),
          1'($urandom),
          1'($urandom),
          W'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
